// File: rtl/cache_lru_ctrl_lv2.sv
// cache_lru_ctrl_lv2
//   Level-2 tree pseudo-LRU replacement controller. It latches an L1 request,
//   returns a registered victim way for the indexed set, then waits for the
//   way actually used and folds that access into the set's PLRU bits. A flush
//   request sweeps every set back to zero, one set per cycle.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   lv2_rd, lv2_wr            request strobes (either or both = one request)
//   addr_bus_lv1_lv2          request address (tag / index / offset fields)
//   lv2_busy                  high whenever the controller is not idle
//   repl_valid                one-cycle pulse qualifying lru_replacement_proc
//   lru_replacement_proc      victim way of the latched set
//   tag_proc                  tag of the latched request
//   blk_access_valid          qualifies blk_accessed_main (WAIT_ACCESS only)
//   blk_accessed_main         way actually hit or filled
//   flush_req                 level request to clear all PLRU state
//   flush_done                pulse during the last flush cycle
module cache_lru_ctrl_lv2 #(
  parameter int ASSOC_WID   = 3,
  parameter int LRU_VAR_WID = 7,
  parameter int NUM_OF_SETS = 1024,
  parameter int ADDR_WID    = 32,
  parameter int INDEX_MSB   = 15,
  parameter int INDEX_LSB   = 6,
  parameter int OFFSET_MSB  = 5,
  parameter int OFFSET_LSB  = 0,
  parameter int TAG_MSB     = 31,
  parameter int TAG_LSB     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lv2_rd,
  input  logic                       lv2_wr,
  input  logic [ADDR_WID-1:0]        addr_bus_lv1_lv2,
  output logic                       lv2_busy,
  output logic                       repl_valid,
  output logic [ASSOC_WID-1:0]       lru_replacement_proc,
  output logic [TAG_MSB-TAG_LSB:0]   tag_proc,
  input  logic                       blk_access_valid,
  input  logic [ASSOC_WID-1:0]       blk_accessed_main,
  input  logic                       flush_req,
  output logic                       flush_done
);

  localparam int IDX_W  = INDEX_MSB - INDEX_LSB + 1;
  localparam int TAG_W  = TAG_MSB - TAG_LSB + 1;
  localparam int OFF_W  = OFFSET_MSB - OFFSET_LSB + 1;
  // node numbers reach 2*WAYS-2, so one bit more than a way number
  localparam int NODE_W = ASSOC_WID + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } req_t;

  logic [1:0]                                state;
  req_t                                      req_in, req_q;
  logic [IDX_W-1:0]                          flush_cnt;
  logic                                      flush_last;
  logic [NUM_OF_SETS-1:0][LRU_VAR_WID-1:0]   plru;
  logic [LRU_VAR_WID-1:0]                    cur_bits, upd_bits, sel;
  logic [NODE_W-1:0]                         vnode, unode, parent;
  logic [ASSOC_WID-1:0]                      victim;
  logic [OFF_W-1:0]                          offset;
  logic                                      unused_offset;

  assign req_in        = {addr_bus_lv1_lv2[TAG_MSB:TAG_LSB], addr_bus_lv1_lv2[INDEX_MSB:INDEX_LSB]};
  // offset is split out for completeness; replacement does not depend on it
  assign offset        = addr_bus_lv1_lv2[OFFSET_MSB:OFFSET_LSB];
  assign unused_offset = ^offset;

  assign tag_proc   = req_q.tag;
  assign lv2_busy   = (state != S_IDLE);
  assign flush_last = (flush_cnt == IDX_W'(NUM_OF_SETS - 1));
  assign flush_done = (state == S_FLUSH) && flush_last;
  assign cur_bits   = plru[req_q.idx];

  // Victim walk: from the root, step to child 2n+1+bit until a leaf is hit.
  // Leaf numbers start at LRU_VAR_WID, so way = leaf - LRU_VAR_WID.
  always_comb begin
    vnode = '0;
    for (int l = 0; l < ASSOC_WID; l++)
      vnode = (vnode << 1) + NODE_W'(1)
            + NODE_W'(|(cur_bits & (LRU_VAR_WID'(1) << vnode)));
    victim = ASSOC_WID'(vnode - NODE_W'(LRU_VAR_WID));
  end

  // Update walk: climb from the accessed leaf. A left child (odd node) sets
  // its parent to 1 (victim goes right), a right child clears it.
  always_comb begin
    upd_bits = cur_bits;
    parent   = '0;
    sel      = '0;
    unode    = NODE_W'(LRU_VAR_WID) + NODE_W'(blk_accessed_main);
    for (int l = 0; l < ASSOC_WID; l++) begin
      parent   = (unode - NODE_W'(1)) >> 1;
      sel      = LRU_VAR_WID'(1) << parent;
      upd_bits = unode[0] ? (upd_bits | sel) : (upd_bits & ~sel);
      unode    = parent;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      req_q                <= '0;
      repl_valid           <= 1'b0;
      lru_replacement_proc <= '0;
      flush_cnt            <= '0;
    end else begin
      repl_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // flush has priority over a coincident request
          if (flush_req) begin
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else if (lv2_rd || lv2_wr) begin
            req_q <= req_in;
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          lru_replacement_proc <= victim;
          repl_valid           <= 1'b1;
          state                <= S_WAIT;
        end
        S_WAIT: begin
          if (blk_access_valid) state <= S_IDLE;
        end
        S_FLUSH: begin
          flush_cnt <= flush_cnt + IDX_W'(1);
          if (flush_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      plru <= '0;
    else if (state == S_WAIT && blk_access_valid)
      plru[req_q.idx] <= upd_bits;
    else if (state == S_FLUSH)
      plru[flush_cnt] <= '0;
  end

endmodule

// File: tb/tb_cache_lru_ctrl_lv2.sv
module tb_cache_lru_ctrl_lv2;
  localparam int NSETS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lv2_rd = 1'b0, lv2_wr = 1'b0;
  logic [31:0] addr = '0;
  logic        lv2_busy, repl_valid, flush_done;
  logic [2:0]  lru_replacement_proc;
  logic [15:0] tag_proc;
  logic        blk_access_valid = 1'b0;
  logic [2:0]  blk = '0;
  logic        flush_req = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0]  way;
    logic [15:0] tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cache_lru_ctrl_lv2 dut (
    .clk(clk), .rst(rst), .lv2_rd(lv2_rd), .lv2_wr(lv2_wr),
    .addr_bus_lv1_lv2(addr), .lv2_busy(lv2_busy), .repl_valid(repl_valid),
    .lru_replacement_proc(lru_replacement_proc), .tag_proc(tag_proc),
    .blk_access_valid(blk_access_valid), .blk_accessed_main(blk),
    .flush_req(flush_req), .flush_done(flush_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every repl_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (repl_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_repl_valid: got pulse with way %0d tag %0h, expected none",
                 lru_replacement_proc, tag_proc);
      end else begin
        e = sb.pop_front();
        chk("victim", 32'(lru_replacement_proc), 32'(e.way));
        chk("tag_proc", 32'(tag_proc), 32'(e.tag));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the repl_valid edge.
  task automatic do_req(input int idx, input logic [15:0] tag, input logic [2:0] way,
                        input bit wr);
    sb.push_back({way, tag});
    lv2_rd = !wr;
    lv2_wr = wr;
    addr   = {tag, 10'(idx), 6'h2a};
    @(posedge clk);
    #1 chk("busy_on_accept", 32'(lv2_busy), 32'd1);
    chk("repl_not_early", 32'(repl_valid), 32'd0);
    @(negedge clk);
    lv2_rd = 1'b0;
    lv2_wr = 1'b0;
    @(negedge clk);
    chk("repl_valid_t1", 32'(repl_valid), 32'd1);
  endtask

  task automatic do_access(input logic [2:0] way);
    blk_access_valid = 1'b1;
    blk = way;
    @(posedge clk);
    @(negedge clk);
    blk_access_valid = 1'b0;
    chk("busy_after_access", 32'(lv2_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_busy"}, 32'(lv2_busy), 32'd0);
    chk({tagname, "_repl_valid"}, 32'(repl_valid), 32'd0);
    chk({tagname, "_way"}, 32'(lru_replacement_proc), 32'd0);
    chk({tagname, "_tag"}, 32'(tag_proc), 32'd0);
    chk({tagname, "_flush_done"}, 32'(flush_done), 32'd0);
  endtask

  initial begin
    int v9[8];
    int n, nd, at;
    v9 = '{0, 4, 4, 4, 4, 0, 0, 0};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // fresh set: victim 0, busy held until the access arrives
    do_req(5, 16'h1234, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_hold", 32'(lv2_busy), 32'd1);
    do_access(3'd0);
    do_req(5, 16'h1235, 3'd4, 1'b0);
    do_access(3'd4);
    do_req(5, 16'h1236, 3'd2, 1'b0);
    do_access(3'd2);

    // ways 0..7 in order on index 9, hand-walked victims before each access
    for (int i = 0; i < 8; i++) begin
      do_req(9, 16'h0900 + 16'(i), 3'(v9[i]), 1'b1);
      do_access(3'(i));
    end
    do_req(9, 16'h09ff, 3'd0, 1'b0);
    do_access(3'd1);
    do_req(10, 16'h0a00, 3'd0, 1'b0);
    do_access(3'd5);

    // requests while busy are dropped and do not disturb the latched tag
    do_req(11, 16'hbeef, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      lv2_rd = 1'b1;
      addr   = {16'hdead, 10'd12, 6'd0};
      @(negedge clk);
      chk("ignored_busy", 32'(lv2_busy), 32'd1);
      chk("ignored_tag", 32'(tag_proc), 32'hbeef);
    end
    lv2_rd = 1'b0;
    do_access(3'd6);

    // flush beats a simultaneous write; lv2_wr must not produce a lookup
    flush_req = 1'b1;
    lv2_wr    = 1'b1;
    addr      = {16'h7777, 10'd5, 6'd0};
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    lv2_wr    = 1'b0;
    n = 0; nd = 0; at = -1;
    while (lv2_busy === 1'b1 && n < 2000) begin
      n++;
      if (flush_done === 1'b1) begin
        nd++;
        at = n;
      end
      @(negedge clk);
    end
    chk("flush_busy_cycles", 32'(n), 32'(NSETS));
    chk("flush_done_count", 32'(nd), 32'd1);
    chk("flush_done_last", 32'(at), 32'(NSETS));
    do_req(5, 16'h5000, 3'd0, 1'b1);
    do_access(3'd3);
    do_req(9, 16'h5001, 3'd0, 1'b0);
    do_access(3'd1);
    do_req(11, 16'h5002, 3'd0, 1'b0);
    do_access(3'd0);

    // reset in WAIT_ACCESS while repl_valid is high and way 4 is held
    do_req(7, 16'h0777, 3'd0, 1'b0);
    do_access(3'd0);
    do_req(7, 16'h0778, 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(7, 16'h0779, 3'd0, 1'b0);
    do_access(3'd2);

    // reset in the middle of a flush sweep
    do_req(3, 16'h0333, 3'd0, 1'b0);
    do_access(3'd0);
    flush_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_flush_busy", 32'(lv2_busy), 32'd1);
    chk("mid_flush_done", 32'(flush_done), 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_flush");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(3, 16'h0334, 3'd0, 1'b0);
    do_access(3'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_lru_ctrl_lv2.md
# cache_lru_ctrl_lv2

Clocked, parametrised level-2 replacement controller. It accepts a read or write request from level 1, splits the address into tag, index and offset, and looks up the indexed set's tree pseudo-LRU state. It returns a registered victim way, then waits for the way actually accessed and updates that set's PLRU state. It sits between the L1/L2 address bus and the L2 data/tag arrays. Unlike the earlier combinational LRU wrapper, it adds request sequencing, a busy handshake, and a sequential flush sweep.

## Interface
Parameters:
- ASSOC_WID, 3, log2 of ways (WAYS = 2**ASSOC_WID, ≥1)
- LRU_VAR_WID, 7, PLRU bits per set; must equal WAYS-1
- NUM_OF_SETS, 1024, sets; must equal 2**(INDEX_MSB-INDEX_LSB+1)
- ADDR_WID, 32, address width
- INDEX_MSB / INDEX_LSB, 15 / 6, index field
- OFFSET_MSB / OFFSET_LSB, 5 / 0, block offset field
- TAG_MSB / TAG_LSB, 31 / 16, tag field

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lv2_rd  in  1  read request
- lv2_wr  in  1  write request; both high counts as one request
- addr_bus_lv1_lv2  in  ADDR_WID  request address
- lv2_busy  out  1  high whenever state ≠ IDLE; requests are ignored while high
- repl_valid  out  1  one-cycle pulse: lru_replacement_proc is valid
- lru_replacement_proc  out  ASSOC_WID  victim way for the latched set
- tag_proc  out  TAG field width  registered tag of the latched request
- blk_access_valid  in  1  qualifies blk_accessed_main
- blk_accessed_main  in  ASSOC_WID  way actually hit or filled
- flush_req  in  1  level request to clear all PLRU state
- flush_done  out  1  one-cycle pulse when the flush sweep completes

## Operation
- Storage: NUM_OF_SETS × LRU_VAR_WID flops. Reset clears all of them asynchronously.
- Tree PLRU encoding:
  - Node i has children 2i+1 and 2i+2; way w is leaf node LRU_VAR_WID+w.
  - Bit 0 means the victim lies on the left branch; bit 1 means right.
  - Victim: walk from the root following the bits.
  - Update on access of way w: every node on w's path is set to point away from w's branch.
- States: IDLE, LOOKUP, WAIT_ACCESS, FLUSH.
- IDLE:
  - flush_req=1 → FLUSH, flush counter = 0.
  - Otherwise, lv2_rd|lv2_wr → latch index and tag → LOOKUP.
  - Flush wins over a simultaneous request.
- LOOKUP:
  - Compute the victim from the latched set.
  - Register lru_replacement_proc and pulse repl_valid.
  - → WAIT_ACCESS.
- WAIT_ACCESS:
  - Hold until blk_access_valid=1, then write the updated bits for the latched set → IDLE.
  - blk_access_valid in any other state is ignored.
- FLUSH:
  - Clear set[counter] each cycle and increment the counter.
  - After set NUM_OF_SETS-1 is cleared, pulse flush_done → IDLE. The counter width does not wrap early.
  - flush_req asserted outside IDLE stays pending and is serviced on return to IDLE.
- Offset field is decoded but unused.

## Timing
- Reset values: state IDLE, lv2_busy 0, repl_valid 0, lru_replacement_proc 0, tag_proc 0, flush_done 0, flush counter 0, all PLRU bits 0.
- Request sampled at edge T (IDLE). lv2_busy is high from T; repl_valid is high in cycle T+1→T+2 (registered at edge T+1).
- lru_replacement_proc holds its value until the next lookup.
- blk_access_valid sampled at edge U updates the set at U. lv2_busy falls after U, and a new request is accepted at edge U+1.
- Back-to-back requests to the same set see the updated bits.
- Flush: lv2_busy high for NUM_OF_SETS cycles. flush_done pulses in the last FLUSH cycle, and lv2_busy is low the next cycle.
- Reset mid-operation (any state): immediate return to IDLE and all state cleared. No repl_valid or flush_done pulse is emitted.

## Test plan
- Reset, then lv2_rd to index 5 → repl_valid pulses one cycle after acceptance, lru_replacement_proc=0, lv2_busy=1 until access.
- Index 5: access way 0 → next lookup returns way 4. Then access way 4 → next lookup returns way 2.
- Access ways 0..7 in order on index 9 → next lookup returns 0. Index 10 is untouched and returns 0.
- Requests while lv2_busy=1 are ignored: no extra repl_valid, and the latched tag_proc is unchanged.
- Dirty several sets, then flush_req together with lv2_wr in IDLE → flush runs first, flush_done after NUM_OF_SETS cycles, then every set returns victim 0.
- Assert rst mid-WAIT_ACCESS and mid-FLUSH → all outputs return to reset values immediately, and the next lookup returns 0.
